// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge: MEM-stage load/store unit that steers accesses to data memory or
// peripheral windows, raises ADEL/ADES and runs req/ack device transactions with timeout.
module lsu_mem_bridge #(
    parameter logic [31:0] DM_BASE    = 32'h0000_0000,
    parameter logic [31:0] DM_SIZE    = 32'h0000_3000,
    parameter int          NUM_DEV    = 2,
    parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter int          DEV_SPAN   = 12,
    parameter int          RO_OFFSET  = 8,
    parameter int          TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               int_req,
    output logic [31:0]        dm_addr,
    output logic               dm_we,
    output logic [3:0]         dm_be,
    output logic [31:0]        dm_wdata,
    input  logic [31:0]        dm_rdata,
    output logic               dev_req,
    output logic               dev_we,
    output logic [NUM_DEV-1:0] dev_sel,
    output logic [3:0]         dev_addr,
    output logic [31:0]        dev_wdata,
    input  logic               dev_ack,
    input  logic [31:0]        dev_rdata,
    output logic [31:0]        rdata,
    output logic               stall,
    output logic               adel,
    output logic               ades
);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [31:0]        rd_q, rd_d, wd_q, wd_d;
    logic               bf_q, bf_d, we_q, we_d;
    logic [NUM_DEV-1:0] sel_q, sel_d;
    logic [3:0]         off_q, off_d;

    logic [31:0]        dm_off, win_off, lane, dm_ext;
    logic [NUM_DEV-1:0] hit;
    logic               in_dm, in_dev, access, misal, fault, idle, go;

    assign dm_off = addr - DM_BASE;
    assign in_dm  = addr >= DM_BASE && dm_off < DM_SIZE;

    // Offsets below a window base wrap to huge values and fail the span compare.
    always_comb begin
        hit     = '0;
        win_off = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (addr - DEV_BASE - DEV_STRIDE * 32'(k) < 32'(DEV_SPAN)) begin
                hit[k]  = 1'b1;
                win_off = addr - DEV_BASE - DEV_STRIDE * 32'(k);
            end
        end
    end

    assign in_dev = |hit & ~in_dm;
    assign access = mem_rd | mem_wr;
    assign misal  = (size == 2'b01 & addr[0]) | (size == 2'b10 & addr[1:0] != 2'b00);
    assign fault  = access & (misal | size == 2'b11 | ~(in_dm | in_dev) | (in_dev & size != 2'b10)
                    | (in_dev & mem_wr & win_off == 32'(RO_OFFSET)));
    assign idle   = state_q == IDLE;
    assign go     = idle & access & in_dev & ~fault & ~int_req & ~reset;

    assign dm_addr  = {2'b00, dm_off[31:2]};
    assign dm_we    = idle & mem_wr & in_dm & ~fault & ~int_req;
    assign dm_be    = size == 2'b00 ? 4'b0001 << addr[1:0] :
                      size == 2'b01 ? 4'b0011 << addr[1:0] :
                      size == 2'b10 ? 4'b1111 : 4'b0000;
    assign dm_wdata = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    assign lane     = dm_rdata >> {addr[1:0], 3'b000};
    assign dm_ext   = size == 2'b00 ? {{24{sign_ext & lane[7]}}, lane[7:0]} :
                      size == 2'b01 ? {{16{sign_ext & lane[15]}}, lane[15:0]} : lane;

    assign rdata     = state_q == RESP ? (bf_q ? 32'h0 : rd_q) : dm_ext;
    assign adel      = idle ? fault & ~mem_wr : state_q == RESP & bf_q & ~we_q;
    assign ades      = idle ? fault & mem_wr : state_q == RESP & bf_q & we_q;
    assign dev_req   = state_q == REQ;
    assign dev_we    = dev_req & we_q;
    assign dev_sel   = sel_q;
    assign dev_addr  = off_q;
    assign dev_wdata = wd_q;
    assign stall     = go | dev_req;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rd_d    = rd_q;
        bf_d    = bf_q;
        we_d    = we_q;
        sel_d   = sel_q;
        off_d   = off_q;
        wd_d    = wd_q;
        if (go) begin
            state_d = REQ;
            tmr_d   = '0;
            bf_d    = 1'b0;
            we_d    = mem_wr;
            sel_d   = hit;
            off_d   = win_off[3:0];
            wd_d    = wdata;
        end else if (state_q == REQ) begin
            if (dev_ack) begin
                state_d = RESP;
                rd_d    = dev_rdata;
            end else if (tmr_q == TW'(TIMEOUT)) begin
                state_d = RESP;
                bf_d    = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rd_q    <= '0;
            bf_q    <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            off_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rd_q    <= rd_d;
            bf_q    <= bf_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb_lsu_mem_bridge: directed plus random accesses checked against an address-map
// reference model of the load/store bridge with default parameters.
module tb_lsu_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr, sign_ext, int_req, dev_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, dm_rdata, dev_rdata;
    logic [31:0] dm_addr, dm_wdata, dev_wdata, rdata;
    logic        dm_we, dev_req, dev_we, stall, adel, ades;
    logic [3:0]  dm_be, dev_addr;
    logic [1:0]  dev_sel;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_bridge dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .int_req(int_req),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dev_req(dev_req), .dev_we(dev_we), .dev_sel(dev_sel),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_ack(dev_ack),
        .dev_rdata(dev_rdata), .rdata(rdata), .stall(stall), .adel(adel), .ades(ades)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Address map: DM is [0,0x3000); two 16-byte windows at 0x7F00 with 12 live bytes each.
    task automatic model(input logic [31:0] a, input logic [1:0] sz, input bit wr,
                         output bit is_dm, output bit is_dev, output bit flt,
                         output int k, output int off);
        is_dm  = a < 32'h3000;
        is_dev = 0;
        k      = 0;
        off    = 0;
        if (a >= 32'h7F00 && a < 32'h7F20) begin
            k      = int'((a - 32'h7F00) / 16);
            off    = int'((a - 32'h7F00) % 16);
            is_dev = off < 12;
        end
        flt = sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) ||
              (!is_dm && !is_dev) || (is_dev && sz != 2) || (is_dev && wr && off == 8);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sx);
        logic [31:0] v;
        v = d >> (8 * (a % 4));
        if (sz == 0) return (sx && v[7]) ? (v & 32'hFF) | 32'hFFFF_FF00 : v & 32'hFF;
        if (sz == 1) return (sx && v[15]) ? (v & 32'hFFFF) | 32'hFFFF_0000 : v & 32'hFFFF;
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 0) return 32'(1 << (a % 4));
        if (sz == 1) return 32'(3 << (a % 4));
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 0) return {4{w[7:0]}};
        if (sz == 1) return {2{w[15:0]}};
        return w;
    endfunction

    // One MEM-stage instruction; ackd is the REQ cycle index at which the device acks (>=16: never).
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] dmr,
                          input bit ir, input int ackd);
        bit is_dm, is_dev, flt, acc, go, timed_out;
        int k, off;
        logic [31:0] dr;
        model(a, sz, wr, is_dm, is_dev, flt, k, off);
        acc = rd | wr;
        go  = acc && is_dev && !flt && !ir;
        mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
        dm_rdata = dmr; int_req = ir; dev_ack = 1'b0;
        @(negedge clk);
        chk("adel", 32'(adel), 32'(acc && flt && !wr));
        chk("ades", 32'(ades), 32'(acc && flt && wr));
        chk("stall", 32'(stall), 32'(go));
        chk("dm_we", 32'(dm_we), 32'(wr && is_dm && !flt && !ir));
        if (acc && is_dm && !flt) begin
            chk("dm_be", 32'(dm_be), ref_be(a, sz));
            chk("dm_addr", dm_addr, a >> 2);
            if (wr) chk("dm_wdata", dm_wdata, ref_wd(wd, sz));
            else chk("dm_rdata_ext", rdata, ref_load(dmr, a, sz, sx));
        end
        if (go) begin
            dr = $urandom;
            timed_out = 1;
            for (int n = 0; n < 16; n++) begin
                @(posedge clk);
                #1;
                dev_ack = n == ackd;
                dev_rdata = n == ackd ? dr : $urandom;
                @(negedge clk);
                chk("req_dev_req", 32'(dev_req), 32'd1);
                chk("req_stall", 32'(stall), 32'd1);
                if (n == 0) begin
                    chk("dev_sel", 32'(dev_sel), 32'(1 << k));
                    chk("dev_addr", 32'(dev_addr), 32'(off));
                    chk("dev_we", 32'(dev_we), 32'(wr));
                    if (wr) chk("dev_wdata", dev_wdata, wd);
                end
                if (n == ackd) begin
                    timed_out = 0;
                    break;
                end
            end
            @(posedge clk);
            #1;
            dev_ack = 1'b0;
            dev_rdata = $urandom;
            @(negedge clk);
            chk("resp_dev_req", 32'(dev_req), 32'd0);
            chk("resp_stall", 32'(stall), 32'd0);
            chk("resp_adel", 32'(adel), 32'(timed_out && !wr));
            chk("resp_ades", 32'(ades), 32'(timed_out && wr));
            if (!wr) chk("resp_rdata", rdata, timed_out ? 32'h0 : dr);
        end
        @(posedge clk);
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0; int_req = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        reset = 1'b1;
        mem_rd = 0; mem_wr = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        int_req = 0; dev_ack = 0; dm_rdata = 0; dev_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_dev_req", 32'(dev_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dev_sel", 32'(dev_sel), 32'd0);
        chk("rst_dev_we", 32'(dev_we), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        access(0, 1, 2'b00, 0, 32'h6, 32'hAB, 0, 0, 0);
        access(1, 0, 2'b01, 1, 32'h2, 0, 32'h8001_1234, 0, 0);
        access(1, 0, 2'b01, 0, 32'h2, 0, 32'h8001_1234, 0, 0);
        access(1, 0, 2'b10, 0, 32'h7F14, 0, 0, 0, 2);
        access(0, 1, 2'b10, 0, 32'h7F08, 32'h1234, 0, 0, 0);
        access(0, 1, 2'b01, 0, 32'h7F00, 32'h1234, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h3, 0, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h5000, 0, 0, 0, 0);
        access(0, 1, 2'b10, 0, 32'h7F00, 32'hCAFE_F00D, 0, 0, 99);
        access(0, 1, 2'b10, 0, 32'h100, 32'h5555_AAAA, 0, 1, 0);
        access(1, 1, 2'b10, 0, 32'h7F10, 32'h0BAD_BEEF, 0, 0, 1);
        access(1, 0, 2'b11, 0, 32'h8, 0, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h2FFC, 0, 32'h7654_3210, 0, 0);
        access(1, 0, 2'b10, 0, 32'h3000, 0, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h7F0C, 0, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h7F18, 0, 0, 0, 0);
        access(1, 0, 2'b10, 0, 32'h7F20, 0, 0, 0, 0);
        // Reset pulsed while a device load sits in REQ.
        mem_rd = 1; mem_wr = 0; size = 2'b10; addr = 32'h7F04;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_rst_req", 32'(dev_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(dev_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_sel", 32'(dev_sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_rd = 0;
        @(posedge clk);
        #1;
        access(1, 0, 2'b10, 0, 32'h7F04, 0, 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 3);
            sz = 2'($urandom_range(0, 3));
            case (r)
                0: a = 32'($urandom_range(0, 32'h2FFF));
                1: a = 32'h7F00 + 32'($urandom_range(0, 47));
                2: begin a = 32'h7F00 + 32'(16 * $urandom_range(0, 1) + 4 * $urandom_range(0, 2)); sz = 2'b10; end
                default: a = $urandom;
            endcase
            r = $urandom_range(0, 3);
            access(r[0], r[1], sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0 ? 99 : int'($urandom_range(0, 4)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
